// File: rtl/noc_pkg.sv
// Shared types and field widths for the mesh NoC memory responder.
//   instr_e      : flit instruction codes
//   resp_state_e : responder FSM states
//   flit_t       : flit layout for the default network configuration
//   node_w/flit_w: width helpers for parameterised configurations
package noc_pkg;

   typedef enum logic [2:0] {
      INSTR_NONE = 3'b000,
      READ_REQ   = 3'b001,
      WRITE_REQ  = 3'b010,
      READ_RESP  = 3'b011,
      WRITE_ACK  = 3'b100
   } instr_e;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RDWAIT  = 2'd2,
      ST_SEND    = 2'd3
   } resp_state_e;

   localparam int unsigned PAYLOAD_W = 16;
   localparam int unsigned INSTR_W   = 3;
   localparam int unsigned SEQ_W     = 2;
   localparam int unsigned PKT_W     = 64;
   localparam int unsigned WORD_W    = 32;
   localparam int unsigned ERR_W     = 8;

   localparam int unsigned DEF_NW    = 4;
   localparam int unsigned DEF_PID_W = 5;

   // Node address width; a single-node network still needs one bit.
   function automatic int unsigned node_w(input int unsigned node_count);
      return (node_count <= 1) ? 1 : $clog2(node_count);
   endfunction

   function automatic int unsigned flit_w(input int unsigned nw, input int unsigned pid_w);
      return 1 + 2 * nw + PAYLOAD_W + INSTR_W + pid_w + SEQ_W;
   endfunction

   typedef struct packed {
      logic                   valid;
      logic [DEF_NW-1:0]      dest;
      logic [DEF_NW-1:0]      src;
      logic [PAYLOAD_W-1:0]   payload;
      logic [INSTR_W-1:0]     instr;
      logic [DEF_PID_W-1:0]   pid;
      logic [SEQ_W-1:0]       seq;
   } flit_t;

endpackage

// File: rtl/flit_assembler.sv
// Reassembles 4-flit request packets addressed to this node.
//   flit_i     : incoming flit
//   accept_i   : the flit is taken this cycle if its valid bit is set
//   done_c_o   : seq=3 of a consistent packet is being accepted now
//   err_c_o    : flit dropped (wrong dest) or partial packet discarded
//   packet_c_o : full 64-bit packet, valid with done_c_o
//   src_o/pid_o/instr_o : header latched from seq=0
module flit_assembler
   import noc_pkg::*;
#(
   parameter int unsigned NODE_ID         = 0,
   parameter int unsigned NODE_COUNT      = 16,
   parameter int unsigned PACKET_ID_WIDTH = 5,
   localparam int unsigned NW = node_w(NODE_COUNT),
   localparam int unsigned FW = flit_w(NW, PACKET_ID_WIDTH)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [FW-1:0]              flit_i,
   input  logic                       accept_i,
   output logic                       done_c_o,
   output logic                       err_c_o,
   output logic [PKT_W-1:0]           packet_c_o,
   output logic [NW-1:0]              src_o,
   output logic [PACKET_ID_WIDTH-1:0] pid_o,
   output logic [INSTR_W-1:0]         instr_o
);

   typedef struct packed {
      logic                       valid;
      logic [NW-1:0]              dest;
      logic [NW-1:0]              src;
      logic [PAYLOAD_W-1:0]       payload;
      logic [INSTR_W-1:0]         instr;
      logic [PACKET_ID_WIDTH-1:0] pid;
      logic [SEQ_W-1:0]           seq;
   } lflit_t;

   lflit_t                     f;
   logic [SEQ_W-1:0]           exp_q, exp_d;
   logic [NW-1:0]              src_q, src_d;
   logic [PACKET_ID_WIDTH-1:0] pid_q, pid_d;
   logic [INSTR_W-1:0]         instr_q, instr_d;
   logic [3*PAYLOAD_W-1:0]     pkt_q, pkt_d;
   logic                       match;

   assign f = flit_i;

   // Sequence/src/pid checking; exp_q==0 means no packet in progress.
   always_comb begin
      exp_d    = exp_q;
      src_d    = src_q;
      pid_d    = pid_q;
      instr_d  = instr_q;
      pkt_d    = pkt_q;
      done_c_o = 1'b0;
      err_c_o  = 1'b0;
      match    = 1'b0;
      if (accept_i && f.valid) begin
         if (f.dest != NW'(NODE_ID)) begin
            err_c_o = 1'b1;
         end else begin
            match = (f.seq == exp_q) &&
                    ((exp_q == '0) || ((f.src == src_q) && (f.pid == pid_q)));
            err_c_o = !match;
            if (f.seq == '0) begin
               // A seq=0 flit always (re)starts a packet.
               exp_d   = SEQ_W'(1);
               src_d   = f.src;
               pid_d   = f.pid;
               instr_d = f.instr;
               pkt_d[PAYLOAD_W-1:0] = f.payload;
            end else if (!match) begin
               exp_d = '0;
            end else if (f.seq == SEQ_W'(3)) begin
               exp_d    = '0;
               done_c_o = 1'b1;
            end else begin
               exp_d = exp_q + SEQ_W'(1);
               if (f.seq == SEQ_W'(1)) pkt_d[2*PAYLOAD_W-1:PAYLOAD_W]   = f.payload;
               else                    pkt_d[3*PAYLOAD_W-1:2*PAYLOAD_W] = f.payload;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q   <= '0;
         src_q   <= '0;
         pid_q   <= '0;
         instr_q <= '0;
         pkt_q   <= '0;
      end else begin
         exp_q   <= exp_d;
         src_q   <= src_d;
         pid_q   <= pid_d;
         instr_q <= instr_d;
         pkt_q   <= pkt_d;
      end
   end

   // Last slice comes straight from the flit so the access starts next cycle.
   assign packet_c_o = {f.payload, pkt_q};
   assign src_o      = src_q;
   assign pid_o      = pid_q;
   assign instr_o    = instr_q;

endmodule

// File: rtl/noc_mem_responder.sv
// NoC memory-target endpoint: collects requests, accesses a local
// synchronous RAM and returns a 4-flit response to the requester.
//   flitIn/responderReady : request flits in, ready only while collecting
//   flitOut/networkReady  : registered response flits out, with backpressure
//   ramAddress/wrData/we/rdData : single-port RAM, 1-cycle read latency
//   errCount              : saturating count of dropped/illegal requests
module noc_mem_responder
   import noc_pkg::*;
#(
   parameter int unsigned NODE_ID         = 0,
   parameter int unsigned NODE_COUNT      = 16,
   parameter int unsigned PACKET_ID_WIDTH = 5,
   parameter int unsigned RAM_SIZE        = 1024,
   localparam int unsigned NW = node_w(NODE_COUNT),
   localparam int unsigned FW = flit_w(NW, PACKET_ID_WIDTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [FW-1:0]     flitIn,
   output logic              responderReady,
   output logic [FW-1:0]     flitOut,
   input  logic              networkReady,
   output logic [WORD_W-1:0] ramAddress,
   output logic [WORD_W-1:0] wrData,
   output logic              we,
   input  logic [WORD_W-1:0] rdData,
   output logic [ERR_W-1:0]  errCount
);

   typedef struct packed {
      logic                       valid;
      logic [NW-1:0]              dest;
      logic [NW-1:0]              src;
      logic [PAYLOAD_W-1:0]       payload;
      logic [INSTR_W-1:0]         instr;
      logic [PACKET_ID_WIDTH-1:0] pid;
      logic [SEQ_W-1:0]           seq;
   } lflit_t;

   logic                       asm_done_c, asm_err_c;
   logic [PKT_W-1:0]           asm_pkt_c;
   logic [NW-1:0]              asm_src;
   logic [PACKET_ID_WIDTH-1:0] asm_pid;
   logic [INSTR_W-1:0]         asm_instr;

   resp_state_e                state_q, state_d;
   logic [NW-1:0]              src_q, src_d;
   logic [PACKET_ID_WIDTH-1:0] pid_q, pid_d;
   logic [INSTR_W-1:0]         instr_q, instr_d;
   logic [WORD_W-1:0]          addr_q, addr_d, data_q, data_d;
   logic [WORD_W-1:0]          ram_addr_q, ram_addr_d, wr_data_q, wr_data_d;
   logic                       we_q, we_d, oor_q, oor_d;
   logic [SEQ_W-1:0]           k_q, k_d;
   logic [FW-1:0]              flit_q, flit_d;
   logic [ERR_W-1:0]           err_q, err_d;
   logic                       err_inc;
   logic [WORD_W-1:0]          word_idx_c, resp_data_c;
   logic                       oor_c;
   logic [INSTR_W-1:0]         resp_instr_c;

   assign responderReady = (state_q == ST_COLLECT);

   flit_assembler #(
      .NODE_ID         (NODE_ID),
      .NODE_COUNT      (NODE_COUNT),
      .PACKET_ID_WIDTH (PACKET_ID_WIDTH)
   ) u_asm (
      .clk        (clk),
      .rst_n      (rst_n),
      .flit_i     (flitIn),
      .accept_i   (responderReady),
      .done_c_o   (asm_done_c),
      .err_c_o    (asm_err_c),
      .packet_c_o (asm_pkt_c),
      .src_o      (asm_src),
      .pid_o      (asm_pid),
      .instr_o    (asm_instr)
   );

   function automatic logic [FW-1:0] make_flit(
      input logic [NW-1:0]              dest,
      input logic [PACKET_ID_WIDTH-1:0] pid,
      input logic [INSTR_W-1:0]         instr,
      input logic [SEQ_W-1:0]           k,
      input logic [PKT_W-1:0]           pkt
   );
      lflit_t f;
      f.valid   = 1'b1;
      f.dest    = dest;
      f.src     = NW'(NODE_ID);
      f.payload = PAYLOAD_W'(pkt >> (PAYLOAD_W * k));
      f.instr   = instr;
      f.pid     = pid;
      f.seq     = k;
      return f;
   endfunction

   assign word_idx_c   = {2'b00, asm_pkt_c[PKT_W-1:WORD_W+2]};
   assign oor_c        = (word_idx_c >= WORD_W'(RAM_SIZE));
   assign resp_data_c  = oor_q ? '0 : ((instr_q == READ_REQ) ? rdData : data_q);
   assign resp_instr_c = (instr_q == READ_REQ) ? INSTR_W'(READ_RESP) : INSTR_W'(WRITE_ACK);

   // Access / read-wait / send sequencing.
   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      pid_d      = pid_q;
      instr_d    = instr_q;
      addr_d     = addr_q;
      data_d     = data_q;
      ram_addr_d = ram_addr_q;
      wr_data_d  = wr_data_q;
      we_d       = we_q;
      oor_d      = oor_q;
      k_d        = k_q;
      flit_d     = flit_q;
      err_inc    = 1'b0;
      err_d      = err_q;
      case (state_q)
         ST_COLLECT: begin
            err_inc = asm_err_c;
            if (asm_done_c) begin
               state_d    = ST_ACCESS;
               src_d      = asm_src;
               pid_d      = asm_pid;
               instr_d    = asm_instr;
               addr_d     = asm_pkt_c[PKT_W-1:WORD_W];
               data_d     = asm_pkt_c[WORD_W-1:0];
               ram_addr_d = word_idx_c;
               wr_data_d  = asm_pkt_c[WORD_W-1:0];
               oor_d      = oor_c;
               we_d       = (asm_instr == WRITE_REQ) && !oor_c;
            end
         end
         ST_ACCESS: begin
            we_d = 1'b0;
            if ((instr_q != READ_REQ) && (instr_q != WRITE_REQ)) begin
               err_inc = 1'b1;
               state_d = ST_COLLECT;
            end else begin
               err_inc = oor_q;
               state_d = ST_RDWAIT;
            end
         end
         ST_RDWAIT: begin
            data_d  = resp_data_c;
            k_d     = '0;
            flit_d  = make_flit(src_q, pid_q, resp_instr_c, '0, {addr_q, resp_data_c});
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (networkReady) begin
               if (k_q == SEQ_W'(3)) begin
                  flit_d  = '0;
                  state_d = ST_COLLECT;
               end else begin
                  k_d    = k_q + SEQ_W'(1);
                  flit_d = make_flit(src_q, pid_q, resp_instr_c, k_q + SEQ_W'(1),
                                     {addr_q, data_q});
               end
            end
         end
         default: state_d = ST_COLLECT;
      endcase
      if (err_inc && (err_q != '1)) err_d = err_q + ERR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_COLLECT;
         src_q      <= '0;
         pid_q      <= '0;
         instr_q    <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         ram_addr_q <= '0;
         wr_data_q  <= '0;
         we_q       <= 1'b0;
         oor_q      <= 1'b0;
         k_q        <= '0;
         flit_q     <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         pid_q      <= pid_d;
         instr_q    <= instr_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         ram_addr_q <= ram_addr_d;
         wr_data_q  <= wr_data_d;
         we_q       <= we_d;
         oor_q      <= oor_d;
         k_q        <= k_d;
         flit_q     <= flit_d;
         err_q      <= err_d;
      end
   end

   assign flitOut    = flit_q;
   assign ramAddress = ram_addr_q;
   assign wrData     = wr_data_q;
   assign we         = we_q;
   assign errCount   = err_q;

endmodule

// File: tb/tb_noc_mem_responder.sv
// Randomised self-checking bench for noc_mem_responder against a
// word-array reference model of the request/response rules.
module tb_noc_mem_responder;
   import noc_pkg::*;

   localparam int unsigned NW       = DEF_NW;
   localparam int unsigned PIDW     = DEF_PID_W;
   localparam int unsigned FW       = flit_w(NW, PIDW);
   localparam int unsigned RAM_SIZE = 1024;

   logic          clk, rst_n;
   logic [FW-1:0] flitIn, flitOut;
   logic          responderReady, networkReady, we;
   logic [31:0]   ramAddress, wrData, rdData;
   logic [7:0]    errCount;

   noc_mem_responder #(
      .NODE_ID(0), .NODE_COUNT(16), .PACKET_ID_WIDTH(5), .RAM_SIZE(RAM_SIZE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flitIn(flitIn), .responderReady(responderReady),
      .flitOut(flitOut), .networkReady(networkReady), .ramAddress(ramAddress),
      .wrData(wrData), .we(we), .rdData(rdData), .errCount(errCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [31:0] ref_mem [RAM_SIZE];
   int          exp_err;
   int          exp_wr;
   int          n_checks;
   int          n_errs;

   // RAM attached to the DUT; reloaded from the model while in reset.
   logic [31:0] mem [RAM_SIZE];
   int          wr_cnt;
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < RAM_SIZE; i++) mem[i] <= ref_mem[i];
         rdData <= '0;
         wr_cnt <= 0;
      end else begin
         if (we) begin
            wr_cnt <= wr_cnt + 1;
            if (ramAddress < RAM_SIZE) mem[ramAddress[9:0]] <= wrData;
         end
         rdData <= (ramAddress < RAM_SIZE) ? mem[ramAddress[9:0]] : 32'hA5A5_5A5A;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic add_err(input int n);
      exp_err = (exp_err + n > 255) ? 255 : exp_err + n;
   endtask

   function automatic logic [FW-1:0] exp_flit(input logic [3:0] dest, input logic [4:0] pid,
                                               input logic [2:0] instr, input int k,
                                               input logic [63:0] pkt);
      flit_t e;
      e.valid   = 1'b1;
      e.dest    = dest;
      e.src     = 4'd0;
      e.payload = pkt[k*16 +: 16];
      e.instr   = (instr == READ_REQ) ? 3'(READ_RESP) : 3'(WRITE_ACK);
      e.pid     = pid;
      e.seq     = 2'(k);
      return e;
   endfunction

   task automatic send_flit(input logic [3:0] dest, input logic [3:0] src,
                            input logic [15:0] payload, input logic [2:0] instr,
                            input logic [4:0] pid, input logic [1:0] seq);
      flit_t f;
      int    n;
      n = 0;
      while (!responderReady && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) chk("ready_timeout", 64'(responderReady), 64'd1);
      f.valid = 1'b1; f.dest = dest; f.src = src; f.payload = payload;
      f.instr = instr; f.pid = pid; f.seq = seq;
      flitIn = f;
      @(posedge clk); #1;
      flitIn = '0;
   endtask

   // No response may appear; the block must be ready and counters match the model.
   task automatic idle_check(input string tag);
      int seen;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (flitOut[FW-1]) seen++;
         @(posedge clk); #1;
      end
      chk({tag, "_no_resp"}, 64'(seen), 64'd0);
      chk({tag, "_ready"}, 64'(responderReady), 64'd1);
      chk({tag, "_err"}, 64'(errCount), 64'(exp_err));
      chk({tag, "_wr"}, 64'(wr_cnt), 64'(exp_wr));
   endtask

   // nr_mode: 0 always ready, 1 random ready, 2 ten-cycle stall after flit 0
   task automatic do_request(input string tag, input logic [3:0] dest, input logic [3:0] src,
                             input logic [4:0] pid, input logic [2:0] instr,
                             input logic [31:0] addr, input logic [31:0] data,
                             input int nr_mode, input bit mid_reset);
      bit          legal_dest, legal_instr, oor, exp_we, nr, pend;
      int unsigned idx;
      logic [31:0] exp_data;
      logic [63:0] pkt;
      logic [FW-1:0] prev;
      int          c, got, first, stall_left;

      legal_dest  = (dest == 4'd0);
      legal_instr = (instr == READ_REQ) || (instr == WRITE_REQ);
      idx         = addr >> 2;
      oor         = (idx >= RAM_SIZE);
      exp_we      = legal_dest && (instr == WRITE_REQ) && !oor;
      exp_data    = '0;
      if (!legal_dest) add_err(4);
      else if (!legal_instr) add_err(1);
      else begin
         if (oor) add_err(1);
         if (instr == WRITE_REQ) begin
            exp_data = oor ? 32'd0 : data;
            if (!oor) begin
               ref_mem[idx] = data;
               exp_wr++;
            end
         end else begin
            exp_data = oor ? 32'd0 : ref_mem[idx];
         end
      end

      pkt = {addr, data};
      for (int k = 0; k < 4; k++) send_flit(dest, src, pkt[k*16 +: 16], instr, pid, 2'(k));

      if (legal_dest) begin
         chk({tag, "_we"}, 64'(we), 64'(exp_we));
         chk({tag, "_ram_addr"}, 64'(ramAddress), 64'({2'b00, addr[31:2]}));
         if (exp_we) chk({tag, "_wr_data"}, 64'(wrData), 64'(data));
      end
      if (!(legal_dest && legal_instr)) begin
         idle_check(tag);
         return;
      end

      pkt = {addr, exp_data};
      c = 1; got = 0; first = 0; stall_left = 10; pend = 1'b0; prev = '0;
      while (got < 4 && c < 200) begin
         if (c == 2) chk({tag, "_we_pulse"}, 64'(we), 64'd0);
         case (nr_mode)
            0:       nr = 1'b1;
            1:       nr = ($urandom_range(0, 3) != 0);
            default: nr = !((first != 0) && (stall_left > 0));
         endcase
         networkReady = nr;
         if (pend) chk({tag, "_hold"}, 64'(flitOut), 64'(prev));
         if (flitOut[FW-1]) begin
            if (first == 0) begin
               first = c;
               chk({tag, "_first_lat"}, 64'(c), 64'd3);
            end
            if (nr_mode == 2 && !nr) begin
               stall_left--;
               chk({tag, "_ready_busy"}, 64'(responderReady), 64'd0);
            end
            if (nr) begin
               chk($sformatf("%s_flit%0d", tag, got), 64'(flitOut),
                   64'(exp_flit(src, pid, instr, got, pkt)));
               got++;
               pend = 1'b0;
            end else begin
               pend = 1'b1;
               prev = flitOut;
            end
         end else if (first != 0) begin
            chk({tag, "_resp_gap"}, 64'(flitOut[FW-1]), 64'd1);
         end
         @(posedge clk); #1;
         c++;
         if (mid_reset && got == 2) break;
      end
      networkReady = 1'b1;

      if (mid_reset) begin
         rst_n = 1'b0;
         #1;
         exp_err = 0;
         exp_wr  = 0;
         chk({tag, "_rst_flit"}, 64'(flitOut), 64'd0);
         chk({tag, "_rst_ready"}, 64'(responderReady), 64'd1);
         chk({tag, "_rst_err"}, 64'(errCount), 64'd0);
         chk({tag, "_rst_we"}, 64'(we), 64'd0);
         repeat (2) @(posedge clk);
         #1 rst_n = 1'b1;
         @(posedge clk); #1;
         chk({tag, "_post_ready"}, 64'(responderReady), 64'd1);
         chk({tag, "_post_flit"}, 64'(flitOut), 64'd0);
         return;
      end

      chk({tag, "_resp_count"}, 64'(got), 64'd4);
      chk({tag, "_done_flit"}, 64'(flitOut), 64'd0);
      chk({tag, "_ready_back"}, 64'(responderReady), 64'd1);
      if (nr_mode == 0) chk({tag, "_done_lat"}, 64'(c), 64'd7);
      chk({tag, "_err"}, 64'(errCount), 64'(exp_err));
      chk({tag, "_wr"}, 64'(wr_cnt), 64'(exp_wr));
   endtask

   initial begin
      n_checks = 0; n_errs = 0; exp_err = 0; exp_wr = 0;
      for (int i = 0; i < RAM_SIZE; i++) ref_mem[i] = $urandom;
      rst_n = 1'b0; flitIn = '0; networkReady = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_flit", 64'(flitOut), 64'd0);
      chk("rst_ready", 64'(responderReady), 64'd1);
      chk("rst_we", 64'(we), 64'd0);
      chk("rst_ram_addr", 64'(ramAddress), 64'd0);
      chk("rst_wr_data", 64'(wrData), 64'd0);
      chk("rst_err", 64'(errCount), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_request("write", 4'd0, 4'd3, 5'd5, 3'(WRITE_REQ), 32'h10, 32'hCAFEBABE, 0, 1'b0);
      do_request("read", 4'd0, 4'd3, 5'd6, 3'(READ_REQ), 32'h10, 32'h0, 0, 1'b0);
      do_request("stall", 4'd0, 4'd7, 5'd9, 3'(READ_REQ), 32'h10, 32'h0, 2, 1'b0);

      // Out-of-order sequence: seq 0 then seq 2
      send_flit(4'd0, 4'd2, 16'h1111, 3'(READ_REQ), 5'd1, 2'd0);
      send_flit(4'd0, 4'd2, 16'h0000, 3'(READ_REQ), 5'd1, 2'd2);
      add_err(1);
      idle_check("ooo");
      do_request("clean", 4'd0, 4'd2, 5'd1, 3'(WRITE_REQ), 32'h24, 32'h1234_5678, 0, 1'b0);

      do_request("wrong_dest", 4'd5, 4'd3, 5'd2, 3'(READ_REQ), 32'h10, 32'h0, 0, 1'b0);
      do_request("oor", 4'd0, 4'd4, 5'd3, 3'(READ_REQ), RAM_SIZE * 4, 32'h0, 0, 1'b0);
      do_request("illegal", 4'd0, 4'd4, 5'd4, 3'd6, 32'h8, 32'h0, 0, 1'b0);

      for (int i = 0; i < 66; i++)
         do_request("sat", 4'd9, 4'd1, 5'd0, 3'(READ_REQ), 32'h0, 32'h0, 0, 1'b0);
      chk("sat_final", 64'(errCount), 64'd255);

      do_request("mid_reset", 4'd0, 4'd3, 5'd8, 3'(READ_REQ), 32'h10, 32'h0, 0, 1'b1);
      do_request("after_rst", 4'd0, 4'd3, 5'd8, 3'(READ_REQ), 32'h24, 32'h0, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [3:0]  dest, src;
         logic [4:0]  pid;
         logic [2:0]  instr;
         logic [31:0] addr;
         int unsigned r, widx;
         dest = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
         src  = 4'($urandom_range(0, 15));
         pid  = 5'($urandom_range(0, 31));
         r    = $urandom_range(0, 9);
         widx = $urandom_range(0, 15);
         if (r < 4) instr = 3'(READ_REQ);
         else if (r < 8) instr = 3'(WRITE_REQ);
         else if (r == 8) instr = 3'($urandom_range(3, 7));
         else begin
            instr = ($urandom_range(0, 1) != 0) ? 3'(READ_REQ) : 3'(WRITE_REQ);
            widx  = RAM_SIZE + $urandom_range(0, 100);
         end
         addr = (widx << 2) | 32'($urandom_range(0, 3));
         do_request($sformatf("rnd%0d", i), dest, src, pid, instr, addr, $urandom,
                    int'($urandom_range(0, 1)), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
